dac_xy_sequencer: RTL and testbench



---
 rtl/dac_seq_pkg.sv | 27 ++
 rtl/dac_seq_timer.sv | 27 ++
 rtl/dac_xy_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_dac_xy_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC X/Y point sequencer.
package dac_seq_pkg;

  typedef logic [11:0] dac_code_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    WAIT_X,
    GAP,
    LOAD_Y,
    WAIT_Y,
    LDAC,
    SETTLE
  } seq_state_t;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dac_seq_timer.sv
// Loadable down-counter shared by the GAP, LDAC and SETTLE states; holds at zero.
module dac_seq_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // A state loaded with N exits on the cycle the count reaches 1, giving N cycles.
  assign done = (count <= WIDTH'(1));

endmodule

// File: rtl/dac_xy_sequencer.sv
// Point sequencer: strobes X (channel A) then Y (channel B) into the DAC driver,
// pulses LDAC, then settles. Optional macro DAC_SKIP_UNCHANGED_EN skips repeated codes.
module dac_xy_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned CS_GAP        = 2,
  parameter int unsigned LDAC_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] in_x,
  input  logic [11:0] in_y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] dac_value,
  output logic        dac_axis,
  output logic        dac_strobe,
  input  logic        dac_ready,
  output logic        ldac_n,
  output logic        busy
);

  localparam int unsigned MAX_COUNT = max3(CS_GAP, LDAC_CYCLES, SETTLE_CYCLES);
  localparam int unsigned CNT_W     = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(CS_GAP);
  localparam logic [CNT_W-1:0] LDAC_LOAD   = CNT_W'(LDAC_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  seq_state_t       state, next_state;
  dac_code_t        x_q, y_q;
  dac_code_t        value_hold;
  logic             axis_hold;
  logic             accept;
  logic             skip_x, skip_y, skip_y_q;
  logic             timer_load, timer_done;
  logic [CNT_W-1:0] timer_value;

  assign in_ready = (state == IDLE) && dac_ready && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign ldac_n   = (state != LDAC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_q <= in_x;
      y_q <= in_y;
    end
  end

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (skip_x && skip_y) begin
            if (SETTLE_CYCLES != 0) begin
              next_state  = SETTLE;
              timer_load  = 1'b1;
              timer_value = SETTLE_LOAD;
            end
          end else if (skip_x) begin
            next_state = LOAD_Y;
          end else begin
            next_state = LOAD_X;
          end
        end
      end
      LOAD_X: next_state = WAIT_X;
      WAIT_X: begin
        if (dac_ready) begin
          if (skip_y_q) begin
            next_state  = LDAC;
            timer_load  = 1'b1;
            timer_value = LDAC_LOAD;
          end else if (CS_GAP == 0) begin
            next_state = LOAD_Y;
          end else begin
            next_state  = GAP;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (timer_done) begin
          next_state = LOAD_Y;
        end
      end
      LOAD_Y: next_state = WAIT_Y;
      WAIT_Y: begin
        if (dac_ready) begin
          next_state  = LDAC;
          timer_load  = 1'b1;
          timer_value = LDAC_LOAD;
        end
      end
      LDAC: begin
        if (timer_done) begin
          if (SETTLE_CYCLES == 0) begin
            next_state = IDLE;
          end else begin
            next_state  = SETTLE;
            timer_load  = 1'b1;
            timer_value = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (timer_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Word outputs decode from registered state; the hold register keeps the last word visible.
  always_comb begin
    dac_value  = value_hold;
    dac_axis   = axis_hold;
    dac_strobe = 1'b0;
    case (state)
      LOAD_X: begin
        dac_value  = x_q;
        dac_axis   = AXIS_X;
        dac_strobe = 1'b1;
      end
      LOAD_Y: begin
        dac_value  = y_q;
        dac_axis   = AXIS_Y;
        dac_strobe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_hold <= '0;
      axis_hold  <= AXIS_X;
    end else if (dac_strobe) begin
      value_hold <= dac_value;
      axis_hold  <= dac_axis;
    end
  end

`ifdef DAC_SKIP_UNCHANGED_EN
  dac_code_t last_x, last_y;
  logic      have_last;

  assign skip_x = have_last && (in_x == last_x);
  assign skip_y = have_last && (in_y == last_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_x    <= '0;
      last_y    <= '0;
      have_last <= 1'b0;
      skip_y_q  <= 1'b0;
    end else begin
      if (accept) begin
        skip_y_q <= skip_y;
      end
      if (dac_strobe) begin
        have_last <= 1'b1;
        if (dac_axis == AXIS_X) begin
          last_x <= dac_value;
        end else begin
          last_y <= dac_value;
        end
      end
    end
  end
`else
  assign skip_x   = 1'b0;
  assign skip_y   = 1'b0;
  assign skip_y_q = 1'b0;
`endif

  dac_seq_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

endmodule

// File: tb/tb_dac_xy_sequencer.sv
// Bench for dac_xy_sequencer: two instances (default and CS_GAP=0/SETTLE=0) with a driver model.
module tb_dac_xy_sequencer;

  localparam int WORD = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       in_valid, in_ready, dac_axis, dac_strobe, dac_ready, ldac_n, busy;
  logic [1:0][11:0] in_x, in_y, dac_value;
  int               wcnt[2];
  int               cyc = 0;
  int               nvec = 0;
  int               nfail = 0;

  typedef struct {int k; logic axis; logic [11:0] val; int cyc; int rise;} strobe_t;
  typedef struct {int k; int width; int start; int rise; int rdy_rise;} pulse_t;
  typedef struct {int k; logic [11:0] x; logic [11:0] y; int period;} vec_t;

  strobe_t    sq[$];
  pulse_t     lq[$];
  int         last_rise[2];
  int         low_start[2];
  int         low_rdy[2];
  logic [1:0] prev_rdy = 2'b11;
  logic [1:0] prev_ldac = 2'b11;

`ifdef DAC_SKIP_UNCHANGED_EN
  logic [1:0]       m_have;
  logic [1:0][11:0] m_lx, m_ly;
`endif

  dac_xy_sequencer u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_x      (in_x[0]),
    .in_y      (in_y[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .dac_value (dac_value[0]),
    .dac_axis  (dac_axis[0]),
    .dac_strobe(dac_strobe[0]),
    .dac_ready (dac_ready[0]),
    .ldac_n    (ldac_n[0]),
    .busy      (busy[0])
  );

  dac_xy_sequencer #(
    .CS_GAP       (0),
    .LDAC_CYCLES  (3),
    .SETTLE_CYCLES(0)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_x      (in_x[1]),
    .in_y      (in_y[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .dac_value (dac_value[1]),
    .dac_axis  (dac_axis[1]),
    .dac_strobe(dac_strobe[1]),
    .dac_ready (dac_ready[1]),
    .ldac_n    (ldac_n[1]),
    .busy      (busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial driver model: busy for WORD cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) wcnt[k] <= 0;
      else if (dac_strobe[k]) wcnt[k] <= WORD;
      else if (wcnt[k] != 0) wcnt[k] <= wcnt[k] - 1;
    end
  end

  always_comb begin
    dac_ready = '0;
    for (int k = 0; k < 2; k++) dac_ready[k] = (wcnt[k] == 0);
  end

  function automatic int p_gap(input int k);
    return (k == 0) ? 2 : 0;
  endfunction
  function automatic int p_ldac(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int p_settle(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dac_ready[k] && !prev_rdy[k]) last_rise[k] <= cyc;
      if (!reset) begin
        if (dac_strobe[k]) begin
          chk("strobe_while_shifting", dac_ready[k], 1);
          sq.push_back('{k, dac_axis[k], dac_value[k], cyc, last_rise[k]});
        end
        if (!ldac_n[k]) begin
          chk("ldac_while_shifting", dac_ready[k], 1);
          if (prev_ldac[k]) begin
            low_start[k] <= cyc;
            low_rdy[k]   <= last_rise[k];
          end
        end else if (!prev_ldac[k]) begin
          lq.push_back('{k, cyc - low_start[k], low_start[k], cyc, low_rdy[k]});
        end
      end
      prev_rdy[k]  <= dac_ready[k];
      prev_ldac[k] <= ldac_n[k];
    end
  end

  // Reference: which words a point sends and how long the point occupies the sequencer.
  function automatic void model_point(input int k, input logic [11:0] x, input logic [11:0] y,
                                      output bit sx, output bit sy);
    sx = 1'b1;
    sy = 1'b1;
`ifdef DAC_SKIP_UNCHANGED_EN
    if (m_have[k] && x == m_lx[k]) sx = 1'b0;
    if (m_have[k] && y == m_ly[k]) sy = 1'b0;
    if (sx) m_lx[k] = x;
    if (sy) m_ly[k] = y;
    if (sx || sy) m_have[k] = 1'b1;
`endif
  endfunction

  function automatic int exp_period(input int k, input bit sx, input bit sy);
    if (sx && sy) return 2 * WORD + p_gap(k) + p_ldac(k) + p_settle(k) + 5;
    if (sx || sy) return WORD + p_ldac(k) + p_settle(k) + 3;
    return p_settle(k) + 1;
  endfunction

  task automatic model_clear();
`ifdef DAC_SKIP_UNCHANGED_EN
    m_have = '0;
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k, input int bound, output bit ok);
    int n;
    n = 0;
    while (!in_ready[k] && n < bound) begin
      tick();
      n++;
    end
    ok = in_ready[k];
  endtask

  task automatic run_point(input int k, input logic [11:0] x, input logic [11:0] y,
                           input bit keep, input int table_per);
    bit      ok, sx, sy;
    int      a, b, per;
    strobe_t s;
    pulse_t  p;
    model_point(k, x, y, sx, sy);
    per = (table_per > 0) ? table_per : exp_period(k, sx, sy);
    in_x[k] = x;
    in_y[k] = y;
    in_valid[k] = 1'b1;
    wait_ready(k, 200, ok);
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid[k] = 1'b0;
      return;
    end
    a = cyc;
    tick();
    if (sx || sy || p_settle(k) > 0) chk("busy_after_accept", busy[k], 1);
    in_x[k] = 12'($urandom);
    in_y[k] = 12'($urandom);
    in_valid[k] = keep;
    wait_ready(k, 400, ok);
    chk("point_done", ok, 1);
    b = cyc;
    chk("period", b - a, per);
    chk("idle_not_busy", busy[k], 0);
    if (sx) begin
      if (sq.size() == 0) chk("x_strobe_missing", 0, 1);
      else begin
        s = sq.pop_front();
        chk("x_axis", s.axis, 0);
        chk("x_value", s.val, x);
      end
    end
    if (sy) begin
      if (sq.size() == 0) chk("y_strobe_missing", 0, 1);
      else begin
        s = sq.pop_front();
        chk("y_axis", s.axis, 1);
        chk("y_value", s.val, y);
        if (sx) chk("cs_gap", s.cyc - s.rise, p_gap(k) + 1);
      end
    end
    chk("extra_strobes", sq.size(), 0);
    if (sx || sy) begin
      if (lq.size() == 0) chk("ldac_missing", 0, 1);
      else begin
        p = lq.pop_front();
        chk("ldac_width", p.width, p_ldac(k));
        chk("ldac_after_word", p.start - p.rdy_rise, 1);
        chk("settle", b - p.rise, p_settle(k));
      end
    end
    chk("extra_ldac", lq.size(), 0);
  endtask

  initial begin
    vec_t        tbl[7];
    bit          ok;
    int          n, k;
    logic [11:0] rx, ry;
    logic [11:0] px[2];
    in_valid = '0;
    in_x     = '0;
    in_y     = '0;
    model_clear();

    tbl[0] = '{0, 12'h123, 12'hABC, 89};
    tbl[1] = '{0, 12'h000, 12'hFFF, 89};
    tbl[2] = '{0, 12'hFFF, 12'h000, 89};
    tbl[3] = '{0, 12'h800, 12'h7FF, 89};
    tbl[4] = '{1, 12'h123, 12'hABC, 72};
    tbl[5] = '{1, 12'h001, 12'hFFE, 72};
    tbl[6] = '{1, 12'hFFF, 12'h000, 72};

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy[0], 0);
    chk("rst_strobe", dac_strobe[0], 0);
    chk("rst_value", dac_value[0], 0);
    chk("rst_axis", dac_axis[0], 0);
    chk("rst_ldac_n", ldac_n[0], 1);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 3);

    for (int i = 0; i < 7; i++) run_point(tbl[i].k, tbl[i].x, tbl[i].y, 1'b0, tbl[i].period);

    // Three points with in_valid held high across them.
    run_point(0, 12'h456, 12'h321, 1'b1, -1);
    run_point(0, 12'h457, 12'h322, 1'b1, -1);
    run_point(0, 12'h458, 12'h323, 1'b0, -1);

    // Reset while the Y word is shifting.
    in_x[0] = 12'h0AA;
    in_y[0] = 12'h055;
    in_valid[0] = 1'b1;
    wait_ready(0, 200, ok);
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (sq.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("reached_y_word", sq.size(), 2);
    tick();
    tick();
    chk("mid_busy_before_rst", busy[0], 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_ldac_n", ldac_n[0], 1);
    chk("mid_rst_strobe", dac_strobe[0], 0);
    chk("mid_rst_value", dac_value[0], 0);
    chk("mid_rst_in_ready", in_ready[0], 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_in_ready_back", in_ready[0], dac_ready[0] ? 1 : 0);
    chk("mid_rst_driver_idle", dac_ready[0], 1);
    sq.delete();
    lq.delete();
    model_clear();

    run_point(0, 12'd5, 12'd7, 1'b0, -1);
    run_point(0, 12'd5, 12'd9, 1'b0, -1);
    run_point(0, 12'd5, 12'd9, 1'b0, -1);

    px[0] = 12'd5;
    px[1] = 12'hFFF;
    for (int i = 0; i < 12; i++) begin
      k  = (i < 6) ? 0 : 1;
      rx = 12'($urandom_range(0, 4095));
      ry = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) rx = px[k];
      px[k] = rx;
      run_point(k, rx, ry, (i == 5 || i == 11) ? 1'b0 : 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
